// File: rtl/controle_venda.sv
// Main vending state machine: latches the product code, accumulates coins in quarters
// against a fixed price table, and sequences dispense, change return and the display state.
module controle_venda #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int MAX_CREDIT     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_valid,
  input  logic [3:0] sel_codigo,
  input  logic       moeda_valid,
  input  logic [1:0] moeda,
  input  logic       cancelar,
  output logic [1:0] estado,
  output logic [3:0] produto,
  output logic [3:0] valorMoedas,
  output logic       devolver,
  output logic       liberar,
  output logic [3:0] troco
);

  localparam int TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ESPERA     = 2'b00,
    PRODUTO    = 2'b01,
    COMPARADOR = 2'b10,
    ENTREGA    = 2'b11
  } state_t;

  state_t        st;
  logic [TW-1:0] timer;
  logic [TW-1:0] dev_cnt;
  logic          cancel_hold;

  logic [4:0] coin_val, sum, preco;
  logic       hold_done, dev_done, timeout_hit, cancel_ev, accept;

  // Price in quarters; zero marks an unlisted (invalid) code.
  function automatic logic [3:0] price(input logic [3:0] c);
    case (c)
      4'b0000: price = 4'd6;
      4'b0100: price = 4'd5;
      4'b0101: price = 4'd3;
      4'b1000: price = 4'd4;
      4'b1001: price = 4'd6;
      4'b1010: price = 4'd7;
      4'b1011: price = 4'd2;
      4'b1100: price = 4'd8;
      4'b1101: price = 4'd8;
      default: price = 4'd0;
    endcase
  endfunction

  always_comb begin
    coin_val = 5'd0;
    case (moeda)
      2'b01:   coin_val = 5'd1;
      2'b10:   coin_val = 5'd2;
      2'b11:   coin_val = 5'd4;
      default: coin_val = 5'd0;
    endcase
    sum         = {1'b0, valorMoedas} + coin_val;
    preco       = {1'b0, price(produto)};
    hold_done   = (timer == TW'(HOLD_CYCLES - 1));
    dev_done    = (dev_cnt == TW'(HOLD_CYCLES - 1));
    timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
    cancel_ev   = cancelar || timeout_hit;
    accept      = moeda_valid && (moeda != 2'b00) && !devolver && (sum <= 5'(MAX_CREDIT));
  end

  assign estado = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ESPERA;
      produto     <= 4'd0;
      valorMoedas <= 4'd0;
      devolver    <= 1'b0;
      liberar     <= 1'b0;
      troco       <= 4'd0;
      timer       <= '0;
      dev_cnt     <= '0;
      cancel_hold <= 1'b0;
    end else begin
      liberar <= 1'b0;
      case (st)
        ESPERA: begin
          timer <= '0;
          if (sel_valid) begin
            st      <= PRODUTO;
            produto <= (price(sel_codigo) != 4'd0) ? sel_codigo : 4'b1111;
          end
        end
        PRODUTO: begin
          timer <= timer + 1'b1;
          if (hold_done) begin
            timer       <= '0;
            dev_cnt     <= '0;
            valorMoedas <= 4'd0;
            st          <= (produto == 4'b1111) ? ESPERA : COMPARADOR;
          end
        end
        COMPARADOR: begin
          if (cancel_hold) begin
            // Refund in progress: the display keeps COMPARADOR while E405 is shown.
            timer <= timer + 1'b1;
            if (hold_done) begin
              st          <= ESPERA;
              timer       <= '0;
              valorMoedas <= 4'd0;
              troco       <= 4'd0;
              devolver    <= 1'b0;
              cancel_hold <= 1'b0;
            end
          end else if (cancel_ev) begin
            cancel_hold <= 1'b1;
            troco       <= valorMoedas;
            devolver    <= 1'b1;
            timer       <= '0;
          end else if (accept) begin
            valorMoedas <= sum[3:0];
            timer       <= '0;
            if (sum >= preco) begin
              st      <= ENTREGA;
              troco   <= 4'(sum - preco);
              liberar <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
            if (devolver) begin
              dev_cnt <= dev_cnt + 1'b1;
              if (dev_done) devolver <= 1'b0;
            end else if (moeda_valid) begin
              devolver <= 1'b1;
              dev_cnt  <= '0;
            end
          end
        end
        ENTREGA: begin
          timer <= timer + 1'b1;
          if (hold_done) begin
            st          <= ESPERA;
            timer       <= '0;
            valorMoedas <= 4'd0;
            troco       <= 4'd0;
            devolver    <= 1'b0;
          end
        end
        default: st <= ESPERA;
      endcase
    end
  end

endmodule
